median_arbiter: RTL and testbench
=================================

# median_arbiter

Round-robin scheduler that shares one three-input `median` unit between N requesters. Each requester hands over three words on a valid/ready handshake. The arbiter captures the words and sequences the median unit through a clear pulse and its compute latency. It then returns the median to the granted requester on a per-requester response handshake. It sits between the filter front-ends and the single `median` instance; the median unit is instantiated outside this block.

## Interface
- N, 4: number of requesters (2..16).
- WIDTH, 32: data word width.
- MED_LAT, 1: cycles from median unit released from clear to `m_median_word` valid (≥1).

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N  requester i has words pending.
- req_ready  out  N  one-hot accept strobe to the granted requester.
- req_word0, req_word1, req_word2  in  N*WIDTH  flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- resp_valid  out  N  one-hot result-valid for the owning requester.
- resp_ready  in  N  requester accepts result.
- resp_data  out  WIDTH  median result, shared by all requesters.
- m_rst_n  out  1  active-low clear to the median unit.
- m_word0, m_word1, m_word2  out  WIDTH  operands to the median unit.
- m_median_word  in  WIDTH  median unit result.
- busy  out  1  high in any state other than IDLE.
- done_count  out  32  completed responses, wraps at 2^32.

## Operation
- States:
  - IDLE: if any `req_valid`, assert `req_ready` for the winner only. On the accept (valid&ready), register the three words, the owner index and the pointer update, then go to CLEAR.
  - CLEAR: `m_rst_n`=0 for exactly one cycle, then go to COMPUTE.
  - COMPUTE: `m_rst_n`=1 for MED_LAT cycles, counted down. On the last cycle, register `m_median_word` into the result register and go to RESPOND.
  - RESPOND: `resp_valid[owner]`=1 and `resp_data`=result, held stable until `resp_ready[owner]`. On that handshake, increment `done_count` and go to IDLE.
- Grant: the first asserted `req_valid` at or after the priority pointer `ptr`, wrapping modulo N. After a grant to index g, `ptr` = (g+1) mod N. No grant means `ptr` is unchanged.
- `m_word0..2` come from the captured registers, never combinationally from requester inputs. They are held from CLEAR through COMPUTE and keep their last value otherwise.
- `resp_ready` on a non-owner index is ignored.
- `req_valid` may drop before being accepted; no state change results.
- Requesters are never accepted outside IDLE, including a `req_valid` that arrives in the same cycle as the RESPOND handshake.

## Timing
- Reset values:
  - State, counters and data: state=IDLE, `ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `m_word0..2`=0, `busy`=0, `done_count`=0.
  - `m_rst_n` is 0 while `rst` is high and 1 in IDLE after reset.
- Latency: accept in cycle t, CLEAR in t+1, COMPUTE in t+2..t+1+MED_LAT, `resp_valid` from t+2+MED_LAT.
- Best-case issue interval: MED_LAT+3 cycles when `resp_ready` is tied high.
- Reset mid-operation aborts the transaction: no response is delivered, `ptr` returns to 0, and `done_count` is cleared.
- `req_ready` is combinational from `req_valid`, `ptr` and state. Every other output is registered or decoded from state.

## Structure
- Package `median_arb_pkg`:
  - state enum (IDLE, CLEAR, COMPUTE, RESPOND);
  - default parameter constants;
  - the helper function returning the MED_LAT counter width, $clog2(MED_LAT+1).
- Sub-module `rr_arbiter`: N-way round-robin grant with inputs req[N] and ptr, outputs grant (one-hot) and grant index. It is purely combinational. The pointer register stays in `median_arbiter`.

## Test plan
- Single request, N=4, MED_LAT=1: requester 2 sends (5, 9, 7) at cycle 1.
  - `req_ready`=4'b0100 in cycle 1; `m_rst_n` low in cycle 2.
  - `resp_valid`=4'b0100 with `resp_data`=7 in cycle 4; `done_count`=1 after the handshake.
- All four requesters held valid, `resp_ready` all high: grants in order 0, 1, 2, 3, 0, spaced 4 cycles apart (MED_LAT+3); `done_count`=5.
- Back-pressure: hold `resp_ready` low for 10 cycles.
  - `resp_valid`/`resp_data` stay stable; no `req_ready` is asserted.
  - `resp_ready[1]` pulsed while the owner is requester 0 has no effect.
- Pointer wrap: `ptr`=3 after granting requester 2; with only requester 1 valid, requester 1 is granted and `ptr` becomes 2.
- Reset in COMPUTE with MED_LAT=4: `rst` for one cycle gives IDLE, `resp_valid`=0, `done_count`=0, and the next grant goes to requester 0.
- Operand ordering: inputs (0xFFFFFFFF, 0, 3) give 3; duplicates (8, 8, 1) give 8.

Source files
------------

// File: rtl/median_arb_pkg.sv
// Shared types and defaults for the median_arbiter slice.
//   state_t        : arbiter sequencing states
//   *_DEF          : default parameter values
//   lat_cnt_width  : width of the median-latency down-counter
package median_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COMPUTE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned MED_LAT_DEF = 1;

    function automatic int unsigned lat_cnt_width(input int unsigned med_lat);
        return $clog2(med_lat + 1);
    endfunction

endpackage

// File: rtl/median_arbiter_rr.sv
// rr_arbiter: purely combinational N-way round-robin grant.
//   req       in  N      request vector
//   ptr       in  IDX_W  index with highest priority this cycle
//   grant     out N      one-hot grant (zero when no request)
//   grant_idx out IDX_W  index of the granted requester
//   grant_any out 1      at least one request is present
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int unsigned IDX_W = $clog2(N);

    int unsigned       idx;
    logic [IDX_W-1:0]  cand;

    // Scan from ptr upwards, wrapping modulo N; the first hit wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx  = (32'(ptr) + k) % N;
            cand = IDX_W'(idx);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/median_arbiter.sv
// median_arbiter: shares one external three-input median unit between N
// requesters using round-robin arbitration.
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester operand handshake (ready one-hot)
//   req_word0..2           flattened operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready  per-requester result handshake (valid one-hot)
//   resp_data              median result for the current owner
//   m_rst_n                active-low clear to the median unit
//   m_word0..2             registered operands to the median unit
//   m_median_word          median unit result
//   busy                   any state other than IDLE
//   done_count             completed responses, wrapping
module median_arbiter
    import median_arb_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned MED_LAT = MED_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_word0,
    input  logic [N*WIDTH-1:0]   req_word1,
    input  logic [N*WIDTH-1:0]   req_word2,
    output logic [N-1:0]         resp_valid,
    input  logic [N-1:0]         resp_ready,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 m_rst_n,
    output logic [WIDTH-1:0]     m_word0,
    output logic [WIDTH-1:0]     m_word1,
    output logic [WIDTH-1:0]     m_word2,
    input  logic [WIDTH-1:0]     m_median_word,
    output logic                 busy,
    output logic [31:0]          done_count
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = lat_cnt_width(MED_LAT);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, owner, gnt_idx;
    logic [N-1:0]       gnt;
    logic               gnt_any;
    logic [WIDTH-1:0]   w0_q, w1_q, w2_q, result_q;
    logic [CNT_W-1:0]   lat_cnt;
    logic               m_rst_n_q;
    logic               accept, lat_last, resp_fire;

    rr_arbiter #(.N(N)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign accept    = (state == IDLE) && gnt_any;
    assign lat_last  = (lat_cnt == '0);
    assign resp_fire = (state == RESPOND) && resp_ready[owner];

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                req_ready = gnt;
                if (gnt_any) state_nxt = CLEAR;
            end
            CLEAR:   state_nxt = COMPUTE;
            COMPUTE: if (lat_last) state_nxt = RESPOND;
            RESPOND: if (resp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            result_q   <= '0;
            lat_cnt    <= '0;
            done_count <= '0;
            m_rst_n_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Registered from next state so the clear pulse lines up with CLEAR.
            m_rst_n_q <= (state_nxt != CLEAR);
            if (accept) begin
                w0_q  <= req_word0[gnt_idx*WIDTH +: WIDTH];
                w1_q  <= req_word1[gnt_idx*WIDTH +: WIDTH];
                w2_q  <= req_word2[gnt_idx*WIDTH +: WIDTH];
                owner <= gnt_idx;
                ptr   <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
            if (state == CLEAR) begin
                lat_cnt <= CNT_W'(MED_LAT - 1);
            end else if (state == COMPUTE && !lat_last) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
            if (state == COMPUTE && lat_last) begin
                result_q <= m_median_word;
            end
            if (resp_fire) begin
                done_count <= done_count + 32'd1;
            end
        end
    end

    assign m_rst_n    = m_rst_n_q;
    assign m_word0    = w0_q;
    assign m_word1    = w1_q;
    assign m_word2    = w2_q;
    assign resp_data  = result_q;
    assign resp_valid = (state == RESPOND) ? (N'(1) << owner) : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_median_arbiter.sv
// Directed bench for median_arbiter (N=4, MED_LAT=1) with a behavioural
// median unit and a scoreboard of expected owner/result per accepted request.
module tb_median_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0]   req_word0, req_word1, req_word2;
    logic [W-1:0]     resp_data, m_word0, m_word1, m_word2, m_median_word;
    logic             m_rst_n, busy;
    logic [31:0]      done_count;

    logic [W-1:0]     w0 [N];
    logic [W-1:0]     w1 [N];
    logic [W-1:0]     w2 [N];

    int n_vec  = 0;
    int n_miss = 0;

    int unsigned      sb_own [$];
    logic [W-1:0]     sb_dat [$];
    int unsigned      mptr = 0;
    int unsigned      mcnt = 0;

    always #5 clk = ~clk;

    median_arbiter #(.N(N), .WIDTH(W), .MED_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_word0     (req_word0),
        .req_word1     (req_word1),
        .req_word2     (req_word2),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .m_rst_n       (m_rst_n),
        .m_word0       (m_word0),
        .m_word1       (m_word1),
        .m_word2       (m_word2),
        .m_median_word (m_median_word),
        .busy          (busy),
        .done_count    (done_count)
    );

    always_comb begin
        req_word0 = '0;
        req_word1 = '0;
        req_word2 = '0;
        for (int i = 0; i < N; i++) begin
            req_word0[i*W +: W] = w0[i];
            req_word1[i*W +: W] = w1[i];
            req_word2[i*W +: W] = w2[i];
        end
    end

    function automatic logic [W-1:0] med3(input logic [W-1:0] a, b, c);
        logic [W-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    // Median unit model: result valid only on the MED_LAT-th cycle after clear.
    always @(posedge clk) begin
        if (!m_rst_n) mcnt <= 0;
        else          mcnt <= mcnt + 1;
    end
    assign m_median_word = (m_rst_n && mcnt == LAT - 1) ?
                           med3(m_word0, m_word1, m_word2) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (|resp_valid) seen = 1'b1;
            else step_cyc();
        end
        if (!seen) check("resp_timeout", 64'(|resp_valid), 64'd1);
    endtask

    // Scoreboard monitor: predict the grant from a reference pointer, push on
    // accept, pop and compare on every response handshake.
    always @(negedge clk) begin
        int unsigned g, idx, o;
        bit          found;
        if (rst) begin
            sb_own.delete();
            sb_dat.delete();
            mptr = 0;
        end else begin
            if (|(req_valid & req_ready)) begin
                g = 0;
                found = 1'b0;
                for (int unsigned k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (!found && req_valid[idx[1:0]]) begin
                        g = idx;
                        found = 1'b1;
                    end
                end
                check("grant", 64'(req_ready), 64'd1 << g);
                sb_own.push_back(g);
                sb_dat.push_back(med3(w0[g], w1[g], w2[g]));
                mptr = (g + 1) % N;
            end
            if (|(resp_valid & resp_ready)) begin
                if (sb_own.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    o = sb_own.pop_front();
                    check("resp_owner", 64'(resp_valid), 64'd1 << o);
                    check("resp_data", 64'(resp_data), 64'(sb_dat.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, last_cyc, cyc;
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        for (int i = 0; i < N; i++) begin
            w0[i] = '0; w1[i] = '0; w2[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_m_word0", 64'(m_word0), 64'd0);
        check("rst_m_word1", 64'(m_word1), 64'd0);
        check("rst_m_word2", 64'(m_word2), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_count", 64'(done_count), 64'd0);
        check("rst_m_rst_n", 64'(m_rst_n), 64'd0);
        step_cyc(); rst = 1'b0;
        step_cyc(); @(negedge clk);
        check("idle_m_rst_n", 64'(m_rst_n), 64'd1);

        // Single request from requester 2.
        step_cyc();
        w0[2] = 5; w1[2] = 9; w2[2] = 7; req_valid = 4'b0100;
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'b0100);
        step_cyc(); req_valid = '0;
        @(negedge clk);
        check("t1_clear_m_rst_n", 64'(m_rst_n), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_m_word0", 64'(m_word0), 64'd5);
        check("t1_m_word1", 64'(m_word1), 64'd9);
        check("t1_m_word2", 64'(m_word2), 64'd7);
        step_cyc(); @(negedge clk);
        check("t1_compute_m_rst_n", 64'(m_rst_n), 64'd1);
        check("t1_compute_no_resp", 64'(resp_valid), 64'd0);
        step_cyc(); resp_ready = 4'b0100;
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'b0100);
        check("t1_resp_data", 64'(resp_data), 64'd7);
        step_cyc(); resp_ready = '0;
        @(negedge clk);
        check("t1_done_count", 64'(done_count), 64'd1);
        check("t1_resp_cleared", 64'(resp_valid), 64'd0);

        // Pointer wrap: ptr=3, only requester 1 valid.
        step_cyc();
        w0[1] = 4; w1[1] = 6; w2[1] = 5; req_valid = 4'b0010;
        @(negedge clk);
        check("wrap_grant1", 64'(req_ready), 64'b0010);
        step_cyc(); req_valid = '0; resp_ready = '1;
        wait_resp(8);
        check("wrap_resp_data", 64'(resp_data), 64'd5);
        step_cyc();
        // ptr should now be 2: with 1 and 3 valid, 3 wins. Duplicate operands.
        w0[3] = 8; w1[3] = 8; w2[3] = 1; req_valid = 4'b1010;
        @(negedge clk);
        check("ptr_after_wrap", 64'(req_ready), 64'b1000);
        step_cyc(); req_valid = '0;
        wait_resp(8);
        check("dup_median", 64'(resp_data), 64'd8);
        step_cyc();
        // ptr=0: requester 0 beats 2. Extreme operands.
        w0[0] = 32'hFFFF_FFFF; w1[0] = 0; w2[0] = 3; req_valid = 4'b0101;
        @(negedge clk);
        check("ptr_wrapped_to0", 64'(req_ready), 64'b0001);
        step_cyc(); req_valid = '0;
        wait_resp(8);
        check("extreme_median", 64'(resp_data), 64'd3);
        step_cyc();

        // Back-pressure with owner 0; others request while busy.
        resp_ready = '0;
        w0[0] = 1; w1[0] = 2; w2[0] = 3; req_valid = 4'b0001;
        @(negedge clk);
        check("bp_grant0", 64'(req_ready), 64'b0001);
        step_cyc();
        w0[1] = 11; w1[1] = 12; w2[1] = 13;
        w0[2] = 21; w1[2] = 22; w2[2] = 23;
        req_valid = 4'b0110;
        wait_resp(8);
        for (int k = 0; k < 10; k++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'b0001);
            check("bp_resp_data", 64'(resp_data), 64'd2);
            check("bp_no_req_ready", 64'(req_ready), 64'd0);
            step_cyc();
            resp_ready = (k == 4) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        step_cyc(); req_valid = '0; resp_ready = 4'b0001;
        @(negedge clk);
        check("bp_resp_before_hs", 64'(resp_valid), 64'b0001);
        step_cyc(); resp_ready = '0;
        @(negedge clk);
        check("bp_done_count", 64'(done_count), 64'd5);
        check("bp_idle", 64'(busy), 64'd0);

        // Reset during COMPUTE aborts the transaction.
        step_cyc();
        w0[2] = 10; w1[2] = 30; w2[2] = 20; req_valid = 4'b0100;
        @(negedge clk);
        check("rc_grant2", 64'(req_ready), 64'b0100);
        step_cyc(); req_valid = '0;
        step_cyc(); rst = 1'b1;
        @(negedge clk);
        check("rc_busy_in_compute", 64'(busy), 64'd1);
        step_cyc(); rst = 1'b0;
        @(negedge clk);
        check("rc_busy", 64'(busy), 64'd0);
        check("rc_resp_valid", 64'(resp_valid), 64'd0);
        check("rc_done_count", 64'(done_count), 64'd0);
        check("rc_resp_data", 64'(resp_data), 64'd0);
        repeat (3) begin
            step_cyc(); @(negedge clk);
            check("rc_no_resp", 64'(resp_valid), 64'd0);
        end

        // All four held valid with resp_ready high.
        step_cyc();
        for (int i = 0; i < N; i++) begin
            w0[i] = i; w1[i] = 10 + i; w2[i] = 20 + i;
        end
        req_valid = '1; resp_ready = '1;
        got = 0; last_cyc = 0; cyc = 0;
        while (got < 5 && cyc < 40) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                check("rr_order", 64'(req_ready), 64'd1 << (got % 4));
                if (got > 0) check("issue_interval", 64'(cyc - last_cyc), 64'd4);
                last_cyc = cyc;
                got++;
            end
            step_cyc();
            cyc++;
            if (got == 5) req_valid = '0;
        end
        check("rr_accept_count", 64'(got), 64'd5);
        req_valid = '0;
        wait_resp(8);
        step_cyc(); resp_ready = '0;
        @(negedge clk);
        check("rr_done_count", 64'(done_count), 64'd5);
        check("rr_idle", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb_own.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
